// File: rtl/i_mem_burst.sv
// i_mem_burst: word-addressed memory serving fixed-length aligned bursts after a fixed latency.
// Optional feature macro MEM_ADDR_CHECK_EN: requests addressing beyond the memory end with o_err.
module i_mem_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH_LOG2 = 19,
    parameter int LATENCY    = 7,
    parameter int BURST_LEN  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic                    i_wvalid,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    output logic                    o_wready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_rvalid,
    output logic                    o_rlast,
    output logic                    o_done,
    output logic                    o_err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int BASE_W = DEPTH_LOG2 - BEAT_W;
    localparam int WAIT_W = $clog2(LATENCY + 1);
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, READ, WRITE} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic                  dir_write_q, dir_write_d;
    logic                  addr_err_q, addr_err_d;
    logic [BASE_W-1:0]     base_q, base_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  ready_q, ready_d;
    logic                  wready_q, wready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  addr_high;
    logic                  addr_unused;

    // The beat counter only supplies the low bits, so a burst never leaves its aligned window.
    assign mem_idx     = {base_q, beat_q};
    assign addr_unused = ^i_req_addr;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_high = (i_req_addr >> (OFF_W + DEPTH_LOG2)) != '0;
`else
    assign addr_high = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dir_write_d = dir_write_q;
        addr_err_d  = addr_err_q;
        base_d      = base_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        ready_d     = ready_q;
        wready_d    = wready_q;
        rvalid_d    = 1'b0;
        rlast_d     = 1'b0;
        rdata_d     = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (i_req_valid && ready_q) begin
                    state_d     = WAIT;
                    ready_d     = 1'b0;
                    dir_write_d = i_req_write;
                    addr_err_d  = addr_high;
                    base_d      = i_req_addr[OFF_W + BEAT_W +: BASE_W];
                    wait_d      = '0;
                    beat_d      = '0;
                end
            end
            WAIT: begin
                // A rejected request shows its err/done pulse while still in WAIT, then leaves.
                if (done_q) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else if (wait_q == WAIT_W'(LATENCY - 1)) begin
                    if (addr_err_q) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (dir_write_q) begin
                        state_d  = WRITE;
                        wready_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        rvalid_d = 1'b1;
                        rdata_d  = mem[mem_idx];
                        beat_d   = beat_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            READ: begin
                if (rlast_q) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    beat_d  = '0;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem[mem_idx];
                    rlast_d  = &beat_q;
                    done_d   = &beat_q;
                    beat_d   = beat_q + 1'b1;
                end
            end
            WRITE: begin
                // wready drops with the done pulse, marking the final cycle of the burst.
                if (!wready_q) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else if (i_wvalid) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (&beat_q) begin
                        wready_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q     <= IDLE;
            dir_write_q <= 1'b0;
            addr_err_q  <= 1'b0;
            base_q      <= '0;
            wait_q      <= '0;
            beat_q      <= '0;
            ready_q     <= 1'b1;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_write_q <= dir_write_d;
            addr_err_q  <= addr_err_d;
            base_q      <= base_d;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            ready_q     <= ready_d;
            wready_q    <= wready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Memory has no reset so its contents survive an aborted burst.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_arst) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    mem[mem_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_req_ready = ready_q;
    assign o_wready    = wready_q;
    assign o_rvalid    = rvalid_q;
    assign o_rlast     = rlast_q;
    assign o_rdata     = rdata_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_i_mem_burst.sv
// Self-checking bench for i_mem_burst: table-driven reads, directed corner sequences and
// randomized bursts compared against an array model of the memory.
module tb_i_mem_burst;
    localparam int DW    = 32;
    localparam int AW    = 64;
    localparam int DL    = 12;
    localparam int LAT   = 7;
    localparam int BL    = 16;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          i_arst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_write;
    logic [AW-1:0] i_req_addr;
    logic          i_wvalid;
    logic [DW-1:0] i_wdata;
    logic [3:0]    i_wstrb;
    logic          o_wready;
    logic [DW-1:0] o_rdata;
    logic          o_rvalid;
    logic          o_rlast;
    logic          o_done;
    logic          o_err;

    always #5 clk = ~clk;

    i_mem_burst #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .LATENCY(LAT), .BURST_LEN(BL)
    ) dut (
        .i_clk(clk), .i_arst(i_arst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr),
        .i_wvalid(i_wvalid), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_wready(o_wready),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rlast(o_rlast),
        .o_done(o_done), .o_err(o_err)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] refMem [DEPTH];
    logic [31:0] wData [BL];
    logic [3:0]  wStrb [BL];
    logic [15:0] wStall;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] first;
        logic [31:0] last;
    } readVec_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Aligned first word of the burst a byte address maps to, wrapping modulo the depth.
    function automatic int baseWord(input logic [63:0] addr);
        return int'(((addr >> 2) % DEPTH) / BL * BL);
    endfunction

    // Presents a request and returns at the falling edge of the first cycle after it is accepted.
    task automatic applyStimulus(input logic wr, input logic [63:0] addr, input string tag);
        int n = 0;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        while (!o_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_accept"}, o_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic readBurst(input int base, input string tag, output logic [31:0] first, output logic [31:0] last);
        int early = 0;
        first = '0;
        last  = '0;
        for (int c = 1; c <= LAT; c++) begin
            if (c > 1) @(negedge clk);
            if (o_rvalid || o_done || o_req_ready) early++;
        end
        checkOutput({tag, "_quiet"}, early, 0);
        for (int k = 0; k < BL; k++) begin
            @(negedge clk);
            checkOutput({tag, "_rvalid"}, o_rvalid, 1);
            checkOutput({tag, "_rdata"}, o_rdata, refMem[base + k]);
            checkOutput({tag, "_flags"}, {o_rlast, o_done, o_req_ready, o_err},
                        {k == BL - 1, k == BL - 1, 1'b0, 1'b0});
            if (k == 0) first = o_rdata;
            if (k == BL - 1) last = o_rdata;
        end
        @(negedge clk);
        checkOutput({tag, "_end"}, {o_rvalid, o_rlast, o_done, o_req_ready, o_rdata}, {4'b0001, 32'h0});
    endtask

    // Drives nBeats write beats from wData/wStrb, idling one cycle before each beat flagged in wStall.
    task automatic writeBurst(input int base, input string tag, input int nBeats);
        int early = 0;
        int n;
        logic ok;
        for (int c = 1; c <= LAT; c++) begin
            if (c > 1) @(negedge clk);
            if (o_wready || o_done || o_req_ready) early++;
        end
        checkOutput({tag, "_quiet"}, early, 0);
        @(negedge clk);
        checkOutput({tag, "_wready_rise"}, o_wready, 1);
        for (int k = 0; k < nBeats; k++) begin
            if (wStall[k]) begin
                i_wvalid = 1'b0;
                checkOutput({tag, "_stall"}, {o_wready, o_done}, 2'b10);
                @(negedge clk);
            end
            i_wvalid = 1'b1;
            i_wdata  = wData[k];
            i_wstrb  = wStrb[k];
            n = 0;
            while (!o_wready && n < 50) begin
                @(negedge clk);
                n++;
            end
            ok = o_wready;
            @(posedge clk);
            if (ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (wStrb[k][b]) refMem[base + k][8*b +: 8] = wData[k][8*b +: 8];
                end
            end
            @(negedge clk);
            i_wvalid = 1'b0;
        end
        if (nBeats == BL) begin
            checkOutput({tag, "_done"}, {o_done, o_wready, o_req_ready, o_err}, 4'b1000);
            @(negedge clk);
            checkOutput({tag, "_idle"}, {o_done, o_wready, o_req_ready}, 3'b001);
        end
    endtask

    // Called at a falling edge; applies one reset cycle and checks the state that follows.
    task automatic pulseReset(input string tag);
        int seen = 0;
        i_arst      = 1'b1;
        i_wvalid    = 1'b0;
        i_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_arst = 1'b0;
        checkOutput({tag, "_state"}, {o_req_ready, o_rvalid, o_rlast, o_wready, o_done, o_err, o_rdata},
                    {6'b100000, 32'h0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_done || o_rvalid || o_wready) seen++;
        end
        checkOutput({tag, "_no_more"}, seen, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        readVec_t    vecs [4];
        logic [31:0] f, l;
        logic [63:0] a;
        int          n, doneCyc, readyCyc, cyc, quiet;

        vecs[0] = '{addr: 64'h44,   first: 32'h10,  last: 32'h1F};
        vecs[1] = '{addr: 64'h0,    first: 32'h0,   last: 32'hF};
        vecs[2] = '{addr: 64'h3FFC, first: 32'hFF0, last: 32'hFFF};
        vecs[3] = '{addr: 64'h1234, first: 32'h480, last: 32'h48F};

        i_arst      = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = '0;
        i_wvalid    = 1'b0;
        i_wdata     = '0;
        i_wstrb     = '0;
        wStall      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            refMem[i]  = 32'(i);
            dut.mem[i] <= 32'(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", {o_req_ready, o_rvalid, o_rlast, o_wready, o_done, o_err, o_rdata},
                    {6'b100000, 32'h0});
        i_arst = 1'b0;

        // Table of reads over the preloaded pattern.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(1'b0, vecs[v].addr, "tbl");
            readBurst(baseWord(vecs[v].addr), "tbl", f, l);
            checkOutput("tbl_first", f, vecs[v].first);
            checkOutput("tbl_last", l, vecs[v].last);
        end

        // Address above the memory: rejected with o_err, or wrapped to word 0.
`ifdef MEM_ADDR_CHECK_EN
        applyStimulus(1'b0, 64'h1_0000_0000, "oob");
        quiet = 0;
        for (int c = 1; c <= LAT; c++) begin
            if (c > 1) @(negedge clk);
            if (o_rvalid || o_done || o_err) quiet++;
        end
        checkOutput("oob_quiet", quiet, 0);
        @(negedge clk);
        checkOutput("oob_err_pulse", {o_err, o_done, o_rvalid, o_req_ready}, 4'b1100);
        @(negedge clk);
        checkOutput("oob_after", {o_err, o_done, o_rvalid, o_req_ready}, 4'b0001);
`else
        applyStimulus(1'b0, 64'h1_0000_0000, "wrap");
        readBurst(baseWord(64'h1_0000_0000), "wrap", f, l);
        checkOutput("wrap_first", f, 32'h0);
        checkOutput("wrap_last", l, 32'hF);
`endif

        // Write burst with stalls before beats 3 and 9, then read it back.
        for (int k = 0; k < BL; k++) begin
            wData[k] = 32'hA0 + 32'(k);
            wStrb[k] = 4'hF;
        end
        wStall = 16'h0208;
        applyStimulus(1'b1, 64'h100, "wr100");
        writeBurst(baseWord(64'h100), "wr100", BL);
        applyStimulus(1'b0, 64'h100, "rd100");
        readBurst(baseWord(64'h100), "rd100", f, l);
        checkOutput("rd100_first", f, 32'hA0);
        checkOutput("rd100_last", l, 32'hAF);

        // Partial byte strobes merge into existing words.
        wStall = '0;
        for (int k = 0; k < BL; k++) begin
            wData[k] = 32'h12345678;
            wStrb[k] = 4'hF;
        end
        applyStimulus(1'b1, 64'h200, "wrfull");
        writeBurst(baseWord(64'h200), "wrfull", BL);
        for (int k = 0; k < BL; k++) begin
            wData[k] = 32'hFFFFFFFF;
            wStrb[k] = 4'b0101;
        end
        applyStimulus(1'b1, 64'h200, "wrstrb");
        writeBurst(baseWord(64'h200), "wrstrb", BL);
        applyStimulus(1'b0, 64'h200, "rdstrb");
        readBurst(baseWord(64'h200), "rdstrb", f, l);
        checkOutput("strb_merge", f, 32'h12FF56FF);

        // Reset during read beat 5.
        applyStimulus(1'b0, 64'h44, "rstrd");
        repeat (12) @(negedge clk);
        checkOutput("rstrd_beat5", {o_rvalid, o_rdata}, {1'b1, refMem[baseWord(64'h44) + 5]});
        pulseReset("rstrd");
        applyStimulus(1'b0, 64'h80, "postrst");
        readBurst(baseWord(64'h80), "postrst", f, l);
        checkOutput("postrst_first", f, 32'h20);

        // Reset after five write beats; those words persist, the rest keep old data.
        for (int k = 0; k < BL; k++) begin
            wData[k] = 32'hC0DE0000 + 32'(k);
            wStrb[k] = 4'hF;
        end
        applyStimulus(1'b1, 64'h400, "rstwr");
        writeBurst(baseWord(64'h400), "rstwr", 5);
        pulseReset("rstwr");
        applyStimulus(1'b0, 64'h400, "rstwr_rd");
        readBurst(baseWord(64'h400), "rstwr_rd", f, l);
        checkOutput("rstwr_first", f, 32'hC0DE0000);
        checkOutput("rstwr_last", l, 32'h10F);

        // Back-to-back requests with valid held high.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_write = 1'b0;
        i_req_addr  = 64'h44;
        n = 0;
        while (!o_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        i_req_addr = 64'h1234;
        cyc      = 1;
        doneCyc  = -1;
        readyCyc = -1;
        while (readyCyc < 0 && cyc < 100) begin
            if (o_done && doneCyc < 0) doneCyc = cyc;
            if (o_req_ready) readyCyc = cyc;
            if (readyCyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("b2b_done_cycle", doneCyc, LAT + BL);
        checkOutput("b2b_ready_cycle", readyCyc, LAT + BL + 1);
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        readBurst(baseWord(64'h1234), "b2b_second", f, l);

        // Randomized bursts against the array model.
        for (int t = 0; t < 30; t++) begin
            a = 64'($urandom_range(0, 32'h7FF));
`ifndef MEM_ADDR_CHECK_EN
            if ($urandom_range(0, 3) == 0) a = a | (64'($urandom) << 14);
`endif
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < BL; k++) begin
                    wData[k] = $urandom;
                    wStrb[k] = 4'($urandom);
                end
                wStall = 16'($urandom & $urandom);
                applyStimulus(1'b1, a, "rnd_wr");
                writeBurst(baseWord(a), "rnd_wr", BL);
            end else begin
                applyStimulus(1'b0, a, "rnd_rd");
                readBurst(baseWord(a), "rnd_rd", f, l);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
